// File: rtl/motor_pkg.sv
// motor_pkg: shared definitions for the motor controller.
//   state_t   - FSM state codes (also driven onto motor_ctrl.state)
//   mode_t    - command mode codes carried by the decoder
//   SAT_GUARD - extra bits used when forming speed +/- dir before clamping
//   cnt_w()   - counter width for a divide-by-n counter (minimum 1 bit)
package motor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_RUN      = 2'b01,
        ST_BRAKE    = 2'b10,
        ST_FAILSAFE = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        MD_STOP  = 2'b00,
        MD_FWD   = 2'b01,
        MD_REV   = 2'b10,
        MD_BRAKE = 2'b11
    } mode_t;

    // speed (unsigned) plus/minus dir (signed) needs one sign bit and one carry bit
    localparam int SAT_GUARD = 2;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// pwm_gen: shared PWM counter with one comparator per side.
//   i_clk, i_rst_n     - clock, async active-low reset
//   i_duty_l/i_duty_r  - duty values, 0 = always low, 2^W-1 = always high
//   o_pwm_l/o_pwm_r    - PWM outputs
// The counter steps once every DIV clocks and runs 0 .. 2^W-2, so a
// period is 2^W-1 steps and the full-scale duty never drops low.
module pwm_gen
    import motor_pkg::*;
#(
    parameter int W   = 4,
    parameter int DIV = 64
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_duty_l,
    input  logic [W-1:0] i_duty_r,
    output logic         o_pwm_l,
    output logic         o_pwm_r
);

    localparam int           DW      = cnt_w(DIV);
    localparam logic [W-1:0] CNT_TOP = W'((1 << W) - 2);

    logic [DW-1:0] r_div;
    logic [W-1:0]  r_cnt;
    logic          w_step;

    assign w_step = (r_div == DW'(DIV - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div <= '0;
            r_cnt <= '0;
        end else begin
            r_div <= w_step ? '0 : r_div + 1'b1;
            if (w_step)
                r_cnt <= (r_cnt == CNT_TOP) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_pwm_l = (r_cnt < i_duty_l);
    assign o_pwm_r = (r_cnt < i_duty_r);

endmodule

// File: rtl/motor_ctrl.sv
// motor_ctrl: differential drive controller.
//   clk, rst                 - clock, async active-low reset
//   cmd_vld                  - strobe; mode/speed_cmd/dir_cmd/err_rate are fresh
//   mode                     - STOP/FWD/REV/BRAKE
//   speed_cmd, dir_cmd       - unsigned speed, signed steering offset
//   err_rate                 - link error rate; high values halve the targets
//   pwm_l, pwm_r             - PWM drive per side
//   rev, brk, fault, state   - direction, brake, failsafe flag, FSM state
// Duties ramp one LSB per ramp tick. A direction change ramps both sides to
// zero, flips rev, then ramps up. Loss of commands for `timeout` clocks
// forces FAILSAFE, which only a STOP command clears.
module motor_ctrl
    import motor_pkg::*;
#(
    parameter int clk_f    = 50_000_000,
    parameter int cmd_l    = 4,
    parameter int pwm_div  = 64,
    parameter int ramp_div = 50_000,
    parameter int timeout  = 25_000_000,
    parameter int err_thr  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_vld,
    input  logic [1:0]       mode,
    input  logic [cmd_l-1:0] speed_cmd,
    input  logic [cmd_l-1:0] dir_cmd,
    input  logic [3:0]       err_rate,
    output logic             pwm_l,
    output logic             pwm_r,
    output logic             rev,
    output logic             brk,
    output logic             fault,
    output logic [1:0]       state
);

    localparam int               SW     = cmd_l + SAT_GUARD;
    localparam int               RW     = cnt_w(ramp_div);
    localparam int               TW     = cnt_w(timeout);
    localparam logic [cmd_l-1:0] D_MAX  = '1;
    // clk_f is informational; a non-positive value parks the ramp
    localparam logic             CLK_OK = (clk_f > 0);

    state_t            r_state, w_state_nxt;
    mode_t             r_mode, w_mode;
    logic [cmd_l-1:0]  r_speed, r_dir;
    logic [3:0]        r_err;
    logic [cmd_l-1:0]  r_dl, r_dr, w_tl, w_tr;
    logic              r_rev;
    logic [RW-1:0]     r_ramp;
    logic [TW-1:0]     r_wd;
    logic              w_ramp_wrap, w_ramp_tick, w_wd_exp, w_zero;
    logic              w_dir_ok, w_want_rev, w_rev_pend, w_drive, w_derate;
    logic signed [SW-1:0] w_spd_s, w_dir_s, w_sum, w_dif;

    function automatic logic [cmd_l-1:0] sat_u(input logic signed [SW-1:0] v);
        if (v < 0)
            return '0;
        if (v > $signed({{SAT_GUARD{1'b0}}, D_MAX}))
            return D_MAX;
        return v[cmd_l-1:0];
    endfunction

    function automatic logic [cmd_l-1:0] step_to(input logic [cmd_l-1:0] cur,
                                                 input logic [cmd_l-1:0] tgt);
        if (cur < tgt)
            return cur + 1'b1;
        if (cur > tgt)
            return cur - 1'b1;
        return cur;
    endfunction

    // ---------------- command capture ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode  <= MD_STOP;
            r_speed <= '0;
            r_dir   <= '0;
            r_err   <= '0;
        end else if (cmd_vld) begin
            r_mode  <= mode_t'(mode);
            r_speed <= speed_cmd;
            r_dir   <= dir_cmd;
            r_err   <= err_rate;
        end
    end

    // the FSM reacts to a command in the cycle it arrives
    assign w_mode = cmd_vld ? mode_t'(mode) : r_mode;

    // ---------------- timers ----------------
    assign w_ramp_wrap = (r_ramp == RW'(ramp_div - 1));
    assign w_ramp_tick = CLK_OK && w_ramp_wrap;
    // a command in the expiry cycle suppresses the timeout
    assign w_wd_exp    = !cmd_vld && (r_wd == TW'(timeout - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ramp <= '0;
            r_wd   <= '0;
        end else begin
            r_ramp <= w_ramp_wrap ? '0 : r_ramp + 1'b1;
            if (cmd_vld)
                r_wd <= '0;
            else if (r_wd != TW'(timeout - 1))
                r_wd <= r_wd + 1'b1;
        end
    end

    // ---------------- targets ----------------
    assign w_zero     = (r_dl == '0) && (r_dr == '0);
    assign w_dir_ok   = (r_mode == MD_FWD) || (r_mode == MD_REV);
    assign w_want_rev = (r_mode == MD_REV);
    assign w_rev_pend = w_dir_ok && (w_want_rev != r_rev);
    assign w_drive    = (r_state == ST_RUN) && w_dir_ok && !w_rev_pend;
    assign w_derate   = (32'(r_err) >= 32'(err_thr));

    assign w_spd_s = $signed({{SAT_GUARD{1'b0}}, r_speed});
    assign w_dir_s = $signed({{SAT_GUARD{r_dir[cmd_l-1]}}, r_dir});
    assign w_sum   = w_spd_s + w_dir_s;
    assign w_dif   = w_spd_s - w_dir_s;

    always_comb begin
        w_tl = '0;
        w_tr = '0;
        if (w_drive) begin
            w_tl = sat_u(w_sum);
            w_tr = sat_u(w_dif);
            if (w_derate) begin
                w_tl = w_tl >> 1;
                w_tr = w_tr >> 1;
            end
        end
    end

    // ---------------- duty ramp and direction ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dl  <= '0;
            r_dr  <= '0;
            r_rev <= 1'b0;
        end else begin
            // clearing on the next state keeps duty at zero from the first
            // BRAKE/FAILSAFE cycle
            if (w_state_nxt == ST_BRAKE || w_state_nxt == ST_FAILSAFE) begin
                r_dl <= '0;
                r_dr <= '0;
            end else if (w_ramp_tick) begin
                r_dl <= step_to(r_dl, w_tl);
                r_dr <= step_to(r_dr, w_tr);
            end
            if (r_state == ST_RUN && w_rev_pend && w_zero)
                r_rev <= w_want_rev;
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_mode == MD_FWD || w_mode == MD_REV)
                    w_state_nxt = ST_RUN;
                else if (w_mode == MD_BRAKE)
                    w_state_nxt = ST_BRAKE;
            end
            ST_RUN: begin
                if (w_mode == MD_BRAKE)
                    w_state_nxt = ST_BRAKE;
                else if (w_mode == MD_STOP && w_zero)
                    w_state_nxt = ST_IDLE;
            end
            ST_BRAKE: begin
                if (w_mode == MD_STOP)
                    w_state_nxt = ST_IDLE;
                else if (w_mode == MD_FWD || w_mode == MD_REV)
                    w_state_nxt = ST_RUN;
            end
            ST_FAILSAFE: begin
                if (cmd_vld && mode_t'(mode) == MD_STOP)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_wd_exp)
            w_state_nxt = ST_FAILSAFE;
    end

    // ---------------- PWM ----------------
    pwm_gen #(
        .W   (cmd_l),
        .DIV (pwm_div)
    ) u_pwm (
        .i_clk    (clk),
        .i_rst_n  (rst),
        .i_duty_l (r_dl),
        .i_duty_r (r_dr),
        .o_pwm_l  (pwm_l),
        .o_pwm_r  (pwm_r)
    );

    assign state = r_state;
    assign rev   = r_rev;
    assign brk   = (r_state == ST_BRAKE) || (r_state == ST_FAILSAFE);
    assign fault = (r_state == ST_FAILSAFE);

endmodule
